// File: rtl/latency_measure.sv
// Display-lag meter: counts TICKS_PER_UNIT-clock units from start_pulse to sensor_trigger and
// publishes current/min/max/block-average statistics as 5-digit packed BCD.
module latency_measure #(
  parameter int TICKS_PER_UNIT = 2700,
  parameter int MAX_UNITS      = 99999,
  parameter int AVG_LOG2       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_pulse,
  input  logic        sensor_trigger,
  input  logic        clear_stats,
  output logic [19:0] bcd_current,
  output logic [19:0] bcd_minimum,
  output logic [19:0] bcd_maximum,
  output logic [19:0] bcd_average,
  output logic        sample_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int              PW             = $clog2(TICKS_PER_UNIT);
  localparam logic [PW-1:0]   PRESCALE_LAST  = PW'(TICKS_PER_UNIT - 1);
  localparam logic [16:0]     UNITS_MAX      = 17'(MAX_UNITS);
  localparam logic [16:0]     MIN_SENTINEL   = 17'h1FFFF;
  localparam int              SW             = 17 + AVG_LOG2;
  localparam int              CW             = AVG_LOG2 + 1;
  localparam logic [CW-1:0]   BLOCK_SIZE     = CW'(1 << AVG_LOG2);

  typedef enum logic {
    CNT_IDLE,
    CNT_ARMED
  } cnt_state_t;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_STATS,
    ENG_CONV,
    ENG_DONE
  } eng_state_t;

  cnt_state_t       cnt_state;
  logic [PW-1:0]    prescaler;
  logic [16:0]      units;
  logic [16:0]      units_next;
  logic             unit_tick;
  logic             capture;
  logic [16:0]      capture_value;

  logic             pending_valid;
  logic [16:0]      pending_value;
  logic             take;

  eng_state_t       eng_state;
  logic [16:0]      sample_reg;
  logic [16:0]      min_val;
  logic [16:0]      max_val;
  logic [16:0]      avg_val;
  logic [16:0]      min_disp;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    sum_next;
  logic [CW-1:0]    blk_cnt;
  logic [CW-1:0]    blk_next;

  logic [19:0]      conv_bcd;
  logic [16:0]      conv_bin;
  logic [1:0]       conv_sel;
  logic [4:0]       bit_cnt;
  logic [19:0]      dd_adj;
  logic [36:0]      dd_shift;
  logic [16:0]      next_operand;
  logic [19:0]      res_cur;
  logic [19:0]      res_min;
  logic [19:0]      res_max;

  assign unit_tick     = (prescaler == PRESCALE_LAST);
  assign units_next    = units + 17'd1;
  assign capture       = (cnt_state == CNT_ARMED) && sensor_trigger && !start_pulse;
  // The sensor edge counts the tick it lands on, so a pending wrap is already included.
  assign capture_value = unit_tick ? units_next : units;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_state <= CNT_IDLE;
      prescaler <= '0;
      units     <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (start_pulse) begin
        cnt_state <= CNT_ARMED;
        prescaler <= '0;
        units     <= '0;
      end else if (cnt_state == CNT_ARMED) begin
        if (sensor_trigger) begin
          cnt_state <= CNT_IDLE;
        end else if (unit_tick) begin
          prescaler <= '0;
          units     <= units_next;
          if (units_next == UNITS_MAX) begin
            cnt_state <= CNT_IDLE;
            timeout   <= 1'b1;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

  assign take = (eng_state == ENG_IDLE) && pending_valid;

  // A fresh capture replaces an unconsumed one; clear_stats discards even a same-edge capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_value <= '0;
    end else if (clear_stats) begin
      pending_valid <= 1'b0;
      pending_value <= '0;
    end else if (capture) begin
      pending_valid <= 1'b1;
      pending_value <= capture_value;
    end else if (take) begin
      pending_valid <= 1'b0;
    end
  end

  assign min_disp = (min_val == MIN_SENTINEL) ? 17'd0 : min_val;
  assign sum_next = sum + SW'(sample_reg);
  assign blk_next = blk_cnt + CW'(1);

  always_comb begin
    dd_adj = conv_bcd;
    for (int d = 0; d < 5; d++) begin
      if (conv_bcd[4*d +: 4] > 4'd4) begin
        dd_adj[4*d +: 4] = conv_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign dd_shift = {dd_adj, conv_bin} << 1;

  always_comb begin
    next_operand = 17'd0;
    case (conv_sel)
      2'd0:    next_operand = min_disp;
      2'd1:    next_operand = max_val;
      2'd2:    next_operand = avg_val;
      default: next_operand = 17'd0;
    endcase
  end

  // Engine: one stats cycle, then four back-to-back 17-step double-dabble conversions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_state    <= ENG_IDLE;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      bcd_current  <= '0;
      bcd_minimum  <= '0;
      bcd_maximum  <= '0;
      bcd_average  <= '0;
      sample_reg   <= '0;
      min_val      <= MIN_SENTINEL;
      max_val      <= '0;
      avg_val      <= '0;
      sum          <= '0;
      blk_cnt      <= '0;
      conv_bcd     <= '0;
      conv_bin     <= '0;
      conv_sel     <= '0;
      bit_cnt      <= '0;
      res_cur      <= '0;
      res_min      <= '0;
      res_max      <= '0;
    end else if (clear_stats) begin
      eng_state    <= ENG_IDLE;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      bcd_current  <= '0;
      bcd_minimum  <= '0;
      bcd_maximum  <= '0;
      bcd_average  <= '0;
      sample_reg   <= '0;
      min_val      <= MIN_SENTINEL;
      max_val      <= '0;
      avg_val      <= '0;
      sum          <= '0;
      blk_cnt      <= '0;
      conv_bcd     <= '0;
      conv_bin     <= '0;
      conv_sel     <= '0;
      bit_cnt      <= '0;
      res_cur      <= '0;
      res_min      <= '0;
      res_max      <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (eng_state)
        ENG_IDLE: begin
          if (pending_valid) begin
            sample_reg <= pending_value;
            busy       <= 1'b1;
            eng_state  <= ENG_STATS;
          end
        end
        ENG_STATS: begin
          if (sample_reg < min_val) min_val <= sample_reg;
          if (sample_reg > max_val) max_val <= sample_reg;
          if (blk_next == BLOCK_SIZE) begin
            avg_val <= sum_next[AVG_LOG2 +: 17];
            sum     <= '0;
            blk_cnt <= '0;
          end else begin
            sum     <= sum_next;
            blk_cnt <= blk_next;
          end
          conv_bin  <= sample_reg;
          conv_bcd  <= '0;
          conv_sel  <= '0;
          bit_cnt   <= '0;
          eng_state <= ENG_CONV;
        end
        ENG_CONV: begin
          if (bit_cnt == 5'd16) begin
            case (conv_sel)
              2'd0: res_cur <= dd_shift[36:17];
              2'd1: res_min <= dd_shift[36:17];
              2'd2: res_max <= dd_shift[36:17];
              default: begin
                bcd_current  <= res_cur;
                bcd_minimum  <= res_min;
                bcd_maximum  <= res_max;
                bcd_average  <= dd_shift[36:17];
                sample_valid <= 1'b1;
                eng_state    <= ENG_DONE;
              end
            endcase
            conv_sel <= conv_sel + 2'd1;
            bit_cnt  <= '0;
            conv_bcd <= '0;
            conv_bin <= next_operand;
          end else begin
            conv_bcd <= dd_shift[36:17];
            conv_bin <= dd_shift[16:0];
            bit_cnt  <= bit_cnt + 5'd1;
          end
        end
        ENG_DONE: begin
          busy      <= 1'b0;
          eng_state <= ENG_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          eng_state <= ENG_IDLE;
        end
      endcase
    end
  end

endmodule
